trap_unit: RTL
==============

# trap_unit

Machine-mode trap sequencer that drives the trap side of the CSR register file. It arbitrates committed synchronous exceptions, enabled machine interrupts and `mret`, then drains the pipeline. It issues the single-cycle trap write (cause and mepc) into the CSR file and redirects fetch to the `mtvec` target, or to `mepc` on return. It sits between the commit stage and the CSR file / fetch unit.

## Interface
Parameters:
- `XLEN`, 32, data/address width (matches `tcore_param`)

Ports:
- `clk_i` in 1: core clock
- `rst_ni` in 1: reset, asynchronous, active-low
- `exc_valid_i` in 1: committing instruction raised an exception
- `exc_cause_i` in 4: exception code (0, 2, 3, 4, 6, 11)
- `exc_pc_i` in XLEN: PC of the faulting instruction
- `irq_sw_i`, `irq_timer_i`, `irq_ext_i` in 1 each: level interrupt requests
- `irq_pc_i` in XLEN: PC of the next instruction to commit (interrupt return point)
- `mstatus_mie_i` in 1: global interrupt enable from the CSR file
- `mie_i` in XLEN: per-source enables; bits 3, 7 and 11 are used
- `mtvec_i` in XLEN: trap vector from the CSR file
- `mepc_i` in XLEN: return address from the CSR file
- `mret_i` in 1: `mret` is committing
- `drain_done_i` in 1: pipeline is empty and quiescent
- `trap_active_o` out 1: one-cycle trap write strobe to the CSR file
- `trap_cause_o` out XLEN: mcause value
- `trap_mepc_o` out XLEN: mepc value
- `mret_o` out 1: one-cycle strobe so the CSR file can restore MIE/MPIE
- `flush_o` out 1: kill in-flight instructions
- `stall_o` out 1: freeze fetch and commit
- `redirect_valid_o` out 1: one-cycle fetch redirect
- `redirect_pc_o` out XLEN: redirect target
- `busy_o` out 1: high whenever the FSM state is not IDLE

## Operation
FSM states: IDLE, DRAIN, COMMIT, REDIRECT.

- **IDLE**, priority order when an event is sampled:
  1. `exc_valid_i`: latch `cause={0, 0…, exc_cause_i}` and `pc=exc_pc_i`; set `is_irq=0`; go to DRAIN.
  2. Pending interrupt. Pending means `mstatus_mie_i && (irq_x_i && mie_i[code])`, with priority ext(11) > sw(3) > timer(7). Latch `cause={1, 0…, code}`, `pc=irq_pc_i`, `is_irq=1`; go to DRAIN.
  3. `mret_i`: latch `target=mepc_i`; go to REDIRECT with `mret_o=1` in that cycle.
- **DRAIN**: `stall_o=1`, `flush_o=1`. Stay until `drain_done_i`=1, then go to COMMIT.
- **COMMIT**: `stall_o=1`; `trap_active_o=1` for exactly one cycle. `trap_cause_o` and `trap_mepc_o` hold the latched values. Compute target:
  - Direct mode (`mtvec_i[1:0]!=1`, or `is_irq=0`): `{mtvec_i[XLEN-1:2], 2'b00}`.
  - Vectored mode with `is_irq=1`: `{mtvec_i[XLEN-1:2], 2'b00} + 4*code`, modulo 2^XLEN (wraps).
  - Next state is REDIRECT.
- **REDIRECT**: `redirect_valid_o=1`, `redirect_pc_o=target`, `stall_o=1`; next state is IDLE.
- Events arriving in non-IDLE states are ignored; the pipeline is stalled and flushed. A level interrupt that is still asserted is re-evaluated in IDLE.
- `trap_cause_o` and `trap_mepc_o` are 0 outside COMMIT.
- `redirect_pc_o` is 0 outside REDIRECT.
- `mret_o` is high only in a REDIRECT entered from `mret`.
- Simultaneous `exc_valid_i` and `mret_i`: the exception wins and `mret` is dropped.
- Simultaneous exception and interrupt: the exception wins.

## Timing
- All outputs are registered or decoded from the state; no combinational path from inputs to outputs.
- Reset (asynchronous, `rst_ni`=0): state goes to IDLE and every output is 0 immediately. This applies at any point, including mid-DRAIN; no partial trap write is emitted.
- Trap latency, event sampled in cycle N:
  - DRAIN in N+1.
  - COMMIT in the cycle after `drain_done_i` is seen (earliest N+2).
  - REDIRECT one cycle later (earliest N+3).
  - IDLE at N+4.
- `mret` latency: sampled in cycle N, REDIRECT plus `mret_o` in N+1, IDLE at N+2.
- `trap_active_o` and `redirect_valid_o` are never high in the same cycle.
- Each is exactly one cycle wide per event.
- `busy_o` = (state != IDLE).

## Test plan
- Illegal instruction: `exc_valid_i=1`, `exc_cause_i=2`, `exc_pc_i=0x100`, `mtvec_i=0x80`, `drain_done_i=1` → COMMIT shows `trap_cause_o=0x2`, `trap_mepc_o=0x100`; next cycle `redirect_pc_o=0x80`.
- Vectored timer IRQ: `irq_timer_i=1`, `mie_i[7]=1`, `mstatus_mie_i=1`, `mtvec_i=0x201`, `irq_pc_i=0x40` → `trap_cause_o=0x80000007`, `trap_mepc_o=0x40`, `redirect_pc_o=0x21C`.
- Priority and masking:
  - ext, sw and timer all asserted with all enables set → cause `0x8000000B`.
  - Same with `mstatus_mie_i=0` → FSM stays IDLE, no outputs.
- Exception and ext IRQ in the same cycle → cause `0x0000000B` (ecall, code 11, bit 31 clear). The IRQ is taken after return to IDLE if still asserted.
- Drain hold: `drain_done_i` held 0 for 5 cycles → `flush_o`/`stall_o` high for 5 cycles and no `trap_active_o`. Then `drain_done_i=1` → COMMIT next cycle.
- Reset and `mret`:
  - `rst_ni` dropped mid-DRAIN → all outputs 0 at once and no trap strobe after release.
  - `mret_i=1` with `mepc_i=0x1234` → next cycle `redirect_valid_o=1`, `redirect_pc_o=0x1234`, `mret_o=1`.

Source files
------------

// File: rtl/trap_unit.sv
// -----------------------------------------------------------------------------
// trap_unit
//   Machine-mode trap sequencer. It sits between the commit stage and the
//   CSR file / fetch unit. On a committed exception, an enabled interrupt or an
//   mret, it drains the pipeline and issues the single-cycle trap write
//   (mcause/mepc). It then redirects fetch to the mtvec target, or to mepc on
//   return.
//
// Ports
//   clk_i, rst_ni              core clock, async active-low reset
//   exc_valid_i/cause_i/pc_i   committing exception and its faulting PC
//   irq_sw/timer/ext_i         level interrupt requests
//   irq_pc_i                   interrupt return point
//   mstatus_mie_i, mie_i       global / per-source interrupt enables
//   mtvec_i, mepc_i            trap vector and return address from the CSR file
//   mret_i                     mret is committing
//   drain_done_i               pipeline empty and quiescent
//   trap_active_o              one-cycle trap write strobe
//   trap_cause_o, trap_mepc_o  mcause / mepc values (zero outside COMMIT)
//   mret_o                     one-cycle MIE/MPIE restore strobe
//   flush_o, stall_o           pipeline kill / freeze
//   redirect_valid_o/pc_o      one-cycle fetch redirect (pc zero otherwise)
//   busy_o                     FSM not idle
// -----------------------------------------------------------------------------
module trap_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            exc_valid_i,
    input  logic [3:0]      exc_cause_i,
    input  logic [XLEN-1:0] exc_pc_i,
    input  logic            irq_sw_i,
    input  logic            irq_timer_i,
    input  logic            irq_ext_i,
    input  logic [XLEN-1:0] irq_pc_i,
    input  logic            mstatus_mie_i,
    input  logic [XLEN-1:0] mie_i,
    input  logic [XLEN-1:0] mtvec_i,
    input  logic [XLEN-1:0] mepc_i,
    input  logic            mret_i,
    input  logic            drain_done_i,
    output logic            trap_active_o,
    output logic [XLEN-1:0] trap_cause_o,
    output logic [XLEN-1:0] trap_mepc_o,
    output logic            mret_o,
    output logic            flush_o,
    output logic            stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            busy_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] cause_q;
    logic [XLEN-1:0] pc_q;
    logic            is_irq_q;

    logic            trap_active_q;
    logic [XLEN-1:0] trap_cause_q;
    logic [XLEN-1:0] trap_mepc_q;
    logic            mret_q;
    logic            flush_q;
    logic            stall_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            irq_pending_s;
    logic [3:0]      irq_code_s;
    logic [XLEN-1:0] base_s;
    logic [XLEN-1:0] target_s;

    // Interrupt arbitration: ext(11) > sw(3) > timer(7), all gated by MIE.
    always_comb begin
        irq_pending_s = 1'b0;
        irq_code_s    = 4'd0;
        if (!mstatus_mie_i) begin
            irq_pending_s = 1'b0;
        end else if (irq_ext_i && mie_i[11]) begin
            irq_pending_s = 1'b1;
            irq_code_s    = 4'd11;
        end else if (irq_sw_i && mie_i[3]) begin
            irq_pending_s = 1'b1;
            irq_code_s    = 4'd3;
        end else if (irq_timer_i && mie_i[7]) begin
            irq_pending_s = 1'b1;
            irq_code_s    = 4'd7;
        end else begin
            irq_pending_s = 1'b0;
        end
    end

    // Trap target: vectored offset only for interrupts in mode 1; the add wraps.
    always_comb begin
        base_s = {mtvec_i[XLEN-1:2], 2'b00};
        if ((mtvec_i[1:0] == 2'b01) && is_irq_q) begin
            target_s = base_s + ({{(XLEN-4){1'b0}}, cause_q[3:0]} << 2);
        end else begin
            target_s = base_s;
        end
    end

    // Sequencer FSM; outputs are loaded with the values of the state being entered.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= IDLE;
            cause_q          <= {XLEN{1'b0}};
            pc_q             <= {XLEN{1'b0}};
            is_irq_q         <= 1'b0;
            trap_active_q    <= 1'b0;
            trap_cause_q     <= {XLEN{1'b0}};
            trap_mepc_q      <= {XLEN{1'b0}};
            mret_q           <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
        end else begin
            trap_active_q    <= 1'b0;
            trap_cause_q     <= {XLEN{1'b0}};
            trap_mepc_q      <= {XLEN{1'b0}};
            mret_q           <= 1'b0;
            flush_q          <= 1'b0;
            stall_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= {XLEN{1'b0}};
            case (state_q)
                IDLE: begin
                    if (exc_valid_i) begin
                        state_q  <= DRAIN;
                        cause_q  <= {{(XLEN-4){1'b0}}, exc_cause_i};
                        pc_q     <= exc_pc_i;
                        is_irq_q <= 1'b0;
                        flush_q  <= 1'b1;
                        stall_q  <= 1'b1;
                    end else if (irq_pending_s) begin
                        state_q  <= DRAIN;
                        cause_q  <= {1'b1, {(XLEN-5){1'b0}}, irq_code_s};
                        pc_q     <= irq_pc_i;
                        is_irq_q <= 1'b1;
                        flush_q  <= 1'b1;
                        stall_q  <= 1'b1;
                    end else if (mret_i) begin
                        state_q          <= REDIRECT;
                        mret_q           <= 1'b1;
                        stall_q          <= 1'b1;
                        redirect_valid_q <= 1'b1;
                        redirect_pc_q    <= mepc_i;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                DRAIN: begin
                    if (drain_done_i) begin
                        state_q       <= COMMIT;
                        stall_q       <= 1'b1;
                        trap_active_q <= 1'b1;
                        trap_cause_q  <= cause_q;
                        trap_mepc_q   <= pc_q;
                    end else begin
                        state_q <= DRAIN;
                        flush_q <= 1'b1;
                        stall_q <= 1'b1;
                    end
                end
                COMMIT: begin
                    state_q          <= REDIRECT;
                    stall_q          <= 1'b1;
                    redirect_valid_q <= 1'b1;
                    redirect_pc_q    <= target_s;
                end
                REDIRECT: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign trap_active_o    = trap_active_q;
    assign trap_cause_o     = trap_cause_q;
    assign trap_mepc_o      = trap_mepc_q;
    assign mret_o           = mret_q;
    assign flush_o          = flush_q;
    assign stall_o          = stall_q;
    assign redirect_valid_o = redirect_valid_q;
    assign redirect_pc_o    = redirect_pc_q;
    assign busy_o           = (state_q != IDLE);

endmodule
